// File: rtl/sbqm.sv
// Bank-queue manager: saturating occupancy counter driven by entry/exit sensors,
// with full/empty flags and a wait-time estimate for the lobby display.
module sbqm #(
   parameter int N  = 3,
   parameter int TS = 3,
   parameter int WW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sensor_a,
   input  logic          sensor_b,
   input  logic [1:0]    Tcount,
   output logic [N-1:0]  Pcount,
   output logic          full,
   output logic          empty,
   output logic [WW-1:0] Wtime
);

   localparam int WMAX = (2**WW) - 1;

   logic [1:0] tellers;
   int         num;
   int         quot;

   assign full  = (Pcount == '1);
   assign empty = (Pcount == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Pcount <= '0;
      end else if (sensor_a && !sensor_b && !full) begin
         Pcount <= Pcount + N'(1);
      end else if (!sensor_a && sensor_b && !empty) begin
         Pcount <= Pcount - N'(1);
      end
   end

   // Ceiling-style estimate: TS*(P+T-1)/T, divisors are fixed constants per branch
   always_comb begin
      tellers = (Tcount == 2'd0) ? 2'd1 : Tcount;
      num     = TS * (32'(Pcount) + 32'(tellers) - 1);
      quot    = 0;
      Wtime   = '0;
      case (tellers)
         2'd1:    quot = num;
         2'd2:    quot = num / 2;
         default: quot = num / 3;
      endcase
      if (Pcount == '0)
         Wtime = '0;
      else if (quot > WMAX)
         Wtime = WW'(WMAX);
      else
         Wtime = quot[WW-1:0];
   end

endmodule

// File: tb/tb_sbqm.sv
// Directed bench for sbqm: reset, fill, teller sweep, drain, cancel, async reset.
module tb_sbqm;

   logic       clk;
   logic       rst;
   logic       sensor_a;
   logic       sensor_b;
   logic [1:0] Tcount;
   logic [2:0] Pcount;
   logic       full;
   logic       empty;
   logic [4:0] Wtime;

   int n_checks = 0;
   int n_errors = 0;

   int exp_p;
   int w_t3 [8] = '{0, 3, 4, 5, 6, 7, 8, 9};
   int w_sweep [4] = '{21, 21, 12, 9};

   sbqm #(.N(3), .TS(3), .WW(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .sensor_a (sensor_a),
      .sensor_b (sensor_b),
      .Tcount   (Tcount),
      .Pcount   (Pcount),
      .full     (full),
      .empty    (empty),
      .Wtime    (Wtime)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst      = 1'b0;
      sensor_a = 1'b1;
      sensor_b = 1'b0;
      Tcount   = 2'd1;

      // reset held with entry sensor active
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_pcount", int'(Pcount), 0);
         check("rst_empty",  int'(empty), 1);
         check("rst_full",   int'(full), 0);
         check("rst_wtime",  int'(Wtime), 0);
      end

      // fill, saturating at 7
      rst = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         exp_p = (i > 7) ? 7 : i;
         check("fill_pcount", int'(Pcount), exp_p);
         check("fill_full",   int'(full), (i >= 7) ? 1 : 0);
         check("fill_wtime",  int'(Wtime), 3 * exp_p);
      end

      // teller sweep at full queue, combinational response
      sensor_a = 1'b0;
      for (int t = 0; t < 4; t++) begin
         Tcount = 2'(t);
         #1;
         check("sweep_wtime",  int'(Wtime), w_sweep[t]);
         check("sweep_pcount", int'(Pcount), 7);
      end

      // drain with three tellers, holding at 0
      @(negedge clk);
      sensor_b = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         exp_p = (7 - i < 0) ? 0 : 7 - i;
         check("drain_pcount", int'(Pcount), exp_p);
         check("drain_wtime",  int'(Wtime), w_t3[exp_p]);
      end
      check("drain_empty", int'(empty), 1);

      // back up to 3, then simultaneous entry/exit cancels
      sensor_a = 1'b1;
      sensor_b = 1'b0;
      Tcount   = 2'd2;
      repeat (3) @(negedge clk);
      check("to3_pcount", int'(Pcount), 3);
      sensor_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("simul_pcount", int'(Pcount), 3);
         check("simul_wtime",  int'(Wtime), 6);
      end

      // up to 5, then async reset between edges
      sensor_b = 1'b0;
      repeat (2) @(negedge clk);
      check("to5_pcount", int'(Pcount), 5);
      check("to5_wtime",  int'(Wtime), 9);
      #2;
      rst = 1'b0;
      #1;
      check("async_pcount", int'(Pcount), 0);
      check("async_empty",  int'(empty), 1);
      check("async_wtime",  int'(Wtime), 0);
      @(negedge clk);
      check("async_hold", int'(Pcount), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
